// File: rtl/ysyx_lsu_ctrl.sv
//------------------------------------------------------------------------------
// Module   : ysyx_lsu_ctrl
// Brief    : Single-outstanding load/store unit between execute stage and data bus.
//            Optional macro YSYX_LSU_MISALIGN_TRAP_EN enables the misalign trap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

module ysyx_lsu_ctrl #(
    parameter int BIT_W = `YSYX_W_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exu_avalid_i,
    input  logic [BIT_W-1:0] exu_addr_i,
    input  logic [BIT_W-1:0] exu_wdata_i,
    input  logic             exu_ren_i,
    input  logic             exu_wen_i,
    input  logic [2:0]       exu_func3_i,
    output logic [BIT_W-1:0] lsu_rdata_o,
    output logic             lsu_rvalid_o,
    output logic             lsu_wready_o,
    output logic             lsu_err_o,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [BIT_W-1:0] bus_addr_o,
    output logic [BIT_W-1:0] bus_wdata_o,
    output logic [3:0]       bus_wstrb_o,
    input  logic             bus_gnt_i,
    input  logic             bus_rsp_valid_i,
    input  logic [BIT_W-1:0] bus_rdata_i,
    input  logic             bus_rsp_err_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]       state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       func3_q, func3_d;
    logic [1:0]       off_q, off_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [BIT_W-1:0] bus_addr_q, bus_addr_d;
    logic [BIT_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_wstrb_q, bus_wstrb_d;
    logic             rvalid_q, rvalid_d;
    logic             wready_q, wready_d;
    logic             err_q, err_d;
    logic [BIT_W-1:0] rdata_q, rdata_d;

    logic             w_accept;
    logic [1:0]       w_off;
    logic             w_is_word;
    logic [3:0]       w_strb;
    logic [BIT_W-1:0] w_wdata_sh;
    logic             w_misalign;
    logic [BIT_W-1:0] w_rsh;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [BIT_W-1:0] w_ld_fmt;

    assign w_accept  = exu_avalid_i & (exu_ren_i | exu_wen_i);
    assign w_off     = exu_addr_i[1:0];
    assign w_is_word = exu_func3_i[1];

    // Word accesses ignore the low address bits; sub-word lanes follow the offset.
    always_comb begin
        w_strb     = 4'b1111;
        w_wdata_sh = exu_wdata_i;
        if (!w_is_word) begin
            w_wdata_sh = exu_wdata_i << {w_off, 3'b000};
            if (exu_func3_i[0]) begin
                w_strb = 4'b0011 << w_off;
            end else begin
                w_strb = 4'b0001 << w_off;
            end
        end
    end

`ifdef YSYX_LSU_MISALIGN_TRAP_EN
    assign w_misalign = w_is_word ? (w_off != 2'b00)
                                  : (exu_func3_i[0] & w_off[0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_rsh  = bus_rdata_i >> {off_q, 3'b000};
    assign w_byte = w_rsh[7:0];
    assign w_half = w_rsh[15:0];

    always_comb begin
        case (func3_q)
            F3_B:    w_ld_fmt = {{(BIT_W-8){w_byte[7]}}, w_byte};
            F3_H:    w_ld_fmt = {{(BIT_W-16){w_half[15]}}, w_half};
            F3_BU:   w_ld_fmt = {{(BIT_W-8){1'b0}}, w_byte};
            F3_HU:   w_ld_fmt = {{(BIT_W-16){1'b0}}, w_half};
            default: w_ld_fmt = bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        func3_d     = func3_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        wready_d    = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    we_d    = exu_wen_i;
                    func3_d = exu_func3_i;
                    off_d   = w_off;
                    if (w_misalign) begin
                        // Trap completes without touching the bus.
                        state_d  = S_DONE;
                        rvalid_d = ~exu_wen_i;
                        wready_d = exu_wen_i;
                        err_d    = 1'b1;
                        if (!exu_wen_i) begin
                            rdata_d = '0;
                        end
                    end else begin
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = exu_wen_i;
                        bus_addr_d  = {exu_addr_i[BIT_W-1:2], 2'b00};
                        bus_wdata_d = exu_wen_i ? w_wdata_sh : '0;
                        bus_wstrb_d = exu_wen_i ? w_strb : 4'b0000;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    bus_req_d = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus_rsp_valid_i) begin
                    state_d  = S_DONE;
                    rvalid_d = ~we_q;
                    wready_d = we_q;
                    err_d    = bus_rsp_err_i;
                    if (!we_q) begin
                        rdata_d = bus_rsp_err_i ? '0 : w_ld_fmt;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            func3_q     <= 3'b000;
            off_q       <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= 4'b0000;
            rvalid_q    <= 1'b0;
            wready_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            func3_q     <= func3_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            rvalid_q    <= rvalid_d;
            wready_q    <= wready_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign lsu_rdata_o  = rdata_q;
    assign lsu_rvalid_o = rvalid_q;
    assign lsu_wready_o = wready_q;
    assign lsu_err_o    = err_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign bus_wstrb_o  = bus_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_lsu_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_ysyx_lsu_ctrl
// Brief    : Directed-vector bench for ysyx_lsu_ctrl (honours YSYX_LSU_MISALIGN_TRAP_EN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        exu_avalid_i;
    logic [31:0] exu_addr_i;
    logic [31:0] exu_wdata_i;
    logic        exu_ren_i;
    logic        exu_wen_i;
    logic [2:0]  exu_func3_i;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rvalid_o;
    logic        lsu_wready_o;
    logic        lsu_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_gnt_i;
    logic        bus_rsp_valid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_rsp_err_i;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] held;

    ysyx_lsu_ctrl #(.BIT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .exu_avalid_i   (exu_avalid_i),
        .exu_addr_i     (exu_addr_i),
        .exu_wdata_i    (exu_wdata_i),
        .exu_ren_i      (exu_ren_i),
        .exu_wen_i      (exu_wen_i),
        .exu_func3_i    (exu_func3_i),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_rvalid_o   (lsu_rvalid_o),
        .lsu_wready_o   (lsu_wready_o),
        .lsu_err_o      (lsu_err_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_wstrb_o    (bus_wstrb_o),
        .bus_gnt_i      (bus_gnt_i),
        .bus_rsp_valid_i(bus_rsp_valid_i),
        .bus_rdata_i    (bus_rdata_i),
        .bus_rsp_err_i  (bus_rsp_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] brdata;
        logic        berr;
        logic [31:0] e_baddr;
        logic [31:0] e_bwdata;
        logic [3:0]  e_strb;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic ren, input logic wen, input logic [2:0] f3,
                                input logic [31:0] brdata, input logic berr,
                                input logic [31:0] e_baddr, input logic [31:0] e_bwdata,
                                input logic [3:0] e_strb, input logic [31:0] e_rdata);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.ren = ren; v.wen = wen; v.f3 = f3;
        v.brdata = brdata; v.berr = berr; v.e_baddr = e_baddr; v.e_bwdata = e_bwdata;
        v.e_strb = e_strb; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " req"},    {31'd0, bus_req_o},    32'd0);
        chk({nm, " we"},     {31'd0, bus_we_o},     32'd0);
        chk({nm, " baddr"},  bus_addr_o,            32'd0);
        chk({nm, " bwdata"}, bus_wdata_o,           32'd0);
        chk({nm, " strb"},   {28'd0, bus_wstrb_o},  32'd0);
        chk({nm, " rvalid"}, {31'd0, lsu_rvalid_o}, 32'd0);
        chk({nm, " wready"}, {31'd0, lsu_wready_o}, 32'd0);
        chk({nm, " err"},    {31'd0, lsu_err_o},    32'd0);
        chk({nm, " rdata"},  lsu_rdata_o,           32'd0);
    endtask

    // One complete access: accept, gnt after gnt_wait stall cycles, rsp in the first RESP cycle.
    task automatic do_txn(input vec_t v, input int gnt_wait, input string nm);
        logic is_ld;
        is_ld = ~v.wen;
        @(negedge clk);
        exu_avalid_i = 1'b1;
        exu_addr_i   = v.addr;
        exu_wdata_i  = v.wdata;
        exu_ren_i    = v.ren;
        exu_wen_i    = v.wen;
        exu_func3_i  = v.f3;
        @(negedge clk);
        chk({nm, " req"},   {31'd0, bus_req_o},   32'd1);
        chk({nm, " baddr"}, bus_addr_o,           v.e_baddr);
        chk({nm, " we"},    {31'd0, bus_we_o},    {31'd0, v.wen});
        chk({nm, " strb"},  {28'd0, bus_wstrb_o}, {28'd0, v.e_strb});
        if (v.wen) chk({nm, " bwdata"}, bus_wdata_o, v.e_bwdata);
        for (int i = 0; i < gnt_wait; i++) begin
            exu_addr_i = ~v.addr;
            @(negedge clk);
            chk({nm, " stall req"},   {31'd0, bus_req_o}, 32'd1);
            chk({nm, " stall baddr"}, bus_addr_o,         v.e_baddr);
        end
        bus_gnt_i = 1'b1;
        @(negedge clk);
        bus_gnt_i = 1'b0;
        chk({nm, " req drop"},  {31'd0, bus_req_o},    32'd0);
        chk({nm, " no early"},  {31'd0, lsu_rvalid_o | lsu_wready_o}, 32'd0);
        bus_rsp_valid_i = 1'b1;
        bus_rdata_i     = v.brdata;
        bus_rsp_err_i   = v.berr;
        @(negedge clk);
        bus_rsp_valid_i = 1'b0;
        bus_rdata_i     = 32'd0;
        bus_rsp_err_i   = 1'b0;
        chk({nm, " rvalid"}, {31'd0, lsu_rvalid_o}, {31'd0, is_ld});
        chk({nm, " wready"}, {31'd0, lsu_wready_o}, {31'd0, v.wen});
        chk({nm, " err"},    {31'd0, lsu_err_o},    {31'd0, v.berr});
        if (is_ld) held = v.e_rdata;
        chk({nm, " rdata"},  lsu_rdata_o, held);
        exu_avalid_i = 1'b0;
        exu_ren_i    = 1'b0;
        exu_wen_i    = 1'b0;
        @(negedge clk);
        chk({nm, " pulse end"}, {30'd0, lsu_rvalid_o, lsu_wready_o}, 32'd0);
        chk({nm, " err end"},   {31'd0, lsu_err_o}, 32'd0);
        chk({nm, " rdata held"}, lsu_rdata_o, held);
        chk({nm, " idle req"},  {31'd0, bus_req_o}, 32'd0);
    endtask

    initial begin
        #500000;
        n_mis++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        vec_t tbl[13];
        vec_t v;

        // addr, wdata, ren, wen, f3, bus rdata, bus err, exp baddr, exp bwdata, exp strb, exp rdata
        tbl[0]  = mk(32'h8000_0004, 32'h0,         1, 0, 3'b010, 32'hDEAD_BEEF, 0, 32'h8000_0004, 32'h0,         4'b0000, 32'hDEAD_BEEF);
        tbl[1]  = mk(32'h8000_0003, 32'h0,         1, 0, 3'b000, 32'h8012_3456, 0, 32'h8000_0000, 32'h0,         4'b0000, 32'hFFFF_FF80);
        tbl[2]  = mk(32'h8000_0003, 32'h0,         1, 0, 3'b100, 32'h8012_3456, 0, 32'h8000_0000, 32'h0,         4'b0000, 32'h0000_0080);
        tbl[3]  = mk(32'h0000_1002, 32'h0000_ABCD, 0, 1, 3'b001, 32'h0,         0, 32'h0000_1000, 32'hABCD_0000, 4'b1100, 32'h0);
        tbl[4]  = mk(32'h0000_2002, 32'h0,         1, 0, 3'b001, 32'h8001_1234, 0, 32'h0000_2000, 32'h0,         4'b0000, 32'hFFFF_8001);
        tbl[5]  = mk(32'h0000_2000, 32'h0,         1, 0, 3'b101, 32'h8001_F234, 0, 32'h0000_2000, 32'h0,         4'b0000, 32'h0000_F234);
        tbl[6]  = mk(32'h0000_3001, 32'h1234_5678, 0, 1, 3'b000, 32'h0,         0, 32'h0000_3000, 32'h3456_7800, 4'b0010, 32'h0);
        tbl[7]  = mk(32'h0000_4000, 32'hCAFE_BABE, 0, 1, 3'b010, 32'h0,         0, 32'h0000_4000, 32'hCAFE_BABE, 4'b1111, 32'h0);
        tbl[8]  = mk(32'h0000_0010, 32'h0,         1, 0, 3'b000, 32'h1234_567F, 0, 32'h0000_0010, 32'h0,         4'b0000, 32'h0000_007F);
        tbl[9]  = mk(32'h0000_0012, 32'h0,         1, 0, 3'b100, 32'hABCD_EF01, 0, 32'h0000_0010, 32'h0,         4'b0000, 32'h0000_00CD);
        tbl[10] = mk(32'h0000_0014, 32'h0,         1, 0, 3'b001, 32'h0000_7FFF, 0, 32'h0000_0014, 32'h0,         4'b0000, 32'h0000_7FFF);
        tbl[11] = mk(32'h0000_2003, 32'h0000_00AA, 0, 1, 3'b000, 32'h0,         0, 32'h0000_2000, 32'hAA00_0000, 4'b1000, 32'h0);
        tbl[12] = mk(32'h0000_5000, 32'h1111_2222, 1, 1, 3'b010, 32'h0,         1, 32'h0000_5000, 32'h1111_2222, 4'b1111, 32'h0);

        rst             = 1'b1;
        exu_avalid_i    = 1'b0;
        exu_addr_i      = 32'd0;
        exu_wdata_i     = 32'd0;
        exu_ren_i       = 1'b0;
        exu_wen_i       = 1'b0;
        exu_func3_i     = 3'b000;
        bus_gnt_i       = 1'b0;
        bus_rsp_valid_i = 1'b0;
        bus_rdata_i     = 32'd0;
        bus_rsp_err_i   = 1'b0;
        held            = 32'd0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // avalid without ren/wen must not start an access
        exu_avalid_i = 1'b1;
        exu_addr_i   = 32'h0000_0100;
        repeat (2) @(negedge clk);
        chk("noop req", {31'd0, bus_req_o}, 32'd0);
        exu_avalid_i = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_txn(tbl[i], 0, $sformatf("vec%0d", i));
        end

        // gnt stalled for 5 cycles, response carries an error
        v = mk(32'h0000_5008, 32'h0, 1, 0, 3'b010, 32'h1234_5678, 1, 32'h0000_5008, 32'h0, 4'b0000, 32'h0);
        do_txn(v, 5, "stall_err");

`ifdef YSYX_LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        exu_avalid_i = 1'b1;
        exu_addr_i   = 32'h0000_1001;
        exu_ren_i    = 1'b1;
        exu_func3_i  = 3'b010;
        @(negedge clk);
        chk("trap lw req",    {31'd0, bus_req_o},    32'd0);
        chk("trap lw rvalid", {31'd0, lsu_rvalid_o}, 32'd1);
        chk("trap lw err",    {31'd0, lsu_err_o},    32'd1);
        chk("trap lw rdata",  lsu_rdata_o,           32'd0);
        held = 32'd0;
        exu_avalid_i = 1'b0;
        exu_ren_i    = 1'b0;
        @(negedge clk);
        chk("trap lw end", {31'd0, lsu_rvalid_o}, 32'd0);
        exu_avalid_i = 1'b1;
        exu_addr_i   = 32'h0000_1003;
        exu_wen_i    = 1'b1;
        exu_func3_i  = 3'b001;
        @(negedge clk);
        chk("trap sh req",    {31'd0, bus_req_o},    32'd0);
        chk("trap sh wready", {31'd0, lsu_wready_o}, 32'd1);
        chk("trap sh err",    {31'd0, lsu_err_o},    32'd1);
        exu_avalid_i = 1'b0;
        exu_wen_i    = 1'b0;
        @(negedge clk);
        chk("trap sh end", {31'd0, lsu_wready_o}, 32'd0);
`else
        v = mk(32'h0000_1001, 32'h0, 1, 0, 3'b010, 32'h5566_7788, 0, 32'h0000_1000, 32'h0, 4'b0000, 32'h5566_7788);
        do_txn(v, 0, "mis_lw");
        v = mk(32'h0000_1003, 32'h0000_BEEF, 0, 1, 3'b001, 32'h0, 0, 32'h0000_1000, 32'hEF00_0000, 4'b1000, 32'h0);
        do_txn(v, 0, "mis_sh");
`endif

        // reset while waiting for the response; the late response must be ignored
        @(negedge clk);
        exu_avalid_i = 1'b1;
        exu_addr_i   = 32'h0000_6000;
        exu_ren_i    = 1'b1;
        exu_func3_i  = 3'b010;
        @(negedge clk);
        bus_gnt_i = 1'b1;
        @(negedge clk);
        bus_gnt_i    = 1'b0;
        rst          = 1'b1;
        exu_avalid_i = 1'b0;
        exu_ren_i    = 1'b0;
        @(negedge clk);
        rst             = 1'b0;
        bus_rsp_valid_i = 1'b1;
        bus_rdata_i     = 32'hFFFF_FFFF;
        @(negedge clk);
        bus_rsp_valid_i = 1'b0;
        bus_rdata_i     = 32'd0;
        chk_idle_outputs("rst_resp");
        @(negedge clk);
        chk_idle_outputs("rst_resp2");
        held = 32'd0;

        do_txn(tbl[0], 0, "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
